wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-high: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have ports pipe_we  in  1  W-stage write enable; pipe_a3  in  5  W-stage destination; pipe_wd  in  32  W-stage data; pipe_pc  in  32  W-stage instruction PC.
REQ-003 SHALL have ports md_issue  in  1  mult/div issue pulse; md_issue_reg  in  5  register reserved by the issue.
REQ-004 SHALL have ports md_done  in  1  mult/div result valid; md_reg  in  5  result destination; md_data  in  32  result; md_pc  in  32  PC of the issuing instruction; md_ready  out  1  FIFO not full.
REQ-005 SHALL have ports rs_q  in  5 and rt_q  in  5  decode-stage source registers; stall  out  1  source register pending.
REQ-006 SHALL have ports grf_we  out  1; grf_a3  out  5; grf_wd  out  32; grf_pc  out  32  (GRF write port plus trace PC); fifo_cnt  out  2; ovf  out  1  sticky overflow flag.
REQ-007 SHALL have parameters DEPTH, default 2, mult/div result FIFO depth; DATA_W, default 32, data width.

Function
REQ-008 SHALL register all grf_* outputs, giving exactly 1 cycle from the accepted source to grf_we high.
REQ-009 SHALL accept an md_done result into the FIFO only when md_ready=1; md_done while full SHALL drop the result and set ovf until reset.
REQ-010 SHALL give the pipeline priority: if pipe_we=1 and pipe_a3!=0, grf_* SHALL carry the pipe_* values next cycle and the FIFO SHALL NOT pop.
REQ-011 SHALL pop the FIFO head onto grf_* next cycle when no pipeline write wins and the FIFO is not empty.
REQ-012 SHALL drive grf_we=0 for any destination 0; a popped entry with md_reg=0 SHALL still be consumed.
REQ-013 SHALL allow a push and a pop of the FIFO in the same cycle, including when full, in which case md_ready=0 is still decided on the pre-pop count.
REQ-014 SHALL keep a 32-bit pending vector; md_issue with md_issue_reg!=0 SHALL set the bit; popping an entry SHALL clear bit md_reg.
REQ-015 SHALL let the set take precedence when a set and a clear hit the same register in one cycle.
REQ-016 SHALL keep pending[0]=0 at all times.
REQ-017 SHALL leave pending unchanged on pipeline writes.
REQ-018 SHALL compute stall combinationally as pending[rs_q] OR pending[rt_q] from current state, with no bypass of same-cycle pops.
REQ-019 SHALL make fifo_cnt equal the current occupancy, 0..DEPTH, and wrap the FIFO read and write pointers modulo DEPTH.

Reset
REQ-020 SHALL, on reset, bring the following to 0: grf_we, grf_a3, grf_wd, grf_pc, fifo_cnt, ovf, pending and the FIFO pointers; md_ready SHALL be 1 and stall SHALL be 0.
REQ-021 SHALL discard all inputs during a reset cycle; in-flight FIFO entries SHALL be lost and never written.

Structure
REQ-022 SHALL have package wb_pkg hold REG_W=5, DATA_W=32, DEPTH=2 and the FIFO entry typedef {reg, data, pc}.
REQ-023 SHALL have sub-module wb_fifo implement the synchronous FIFO with push, pop, full, empty and count; arbitration and the scoreboard SHALL stay in wb_arbiter.

Verification
REQ-024 SHALL cover: pipe_we=1, a3=5, wd=0x1234 with FIFO empty -> next cycle grf_we=1, a3=5, wd=0x1234.
REQ-025 SHALL cover: md_issue reg 8, then rs_q=8 -> stall=1; md_done reg 8 data 0xBEEF with no pipe write -> grf write to $8 one cycle later, pending[8]=0 and stall=0 the same cycle.
REQ-026 SHALL cover: pipe_we held at 1 for 4 cycles while 2 results are pushed -> md_ready=0 and fifo_cnt=2; a third md_done sets ovf=1; with pipe_we=0 the results drain in order over 2 cycles.
REQ-027 SHALL cover: md_issue reg 9 in the same cycle as the pop of a reg-9 entry -> pending[9] stays 1.
REQ-028 SHALL cover: pipe_we=1 with a3=0, and a FIFO entry with reg 0 -> grf_we stays 0 and the entry is popped (fifo_cnt decrements).
REQ-029 SHALL cover: reset asserted with fifo_cnt=2 and pending nonzero -> next cycle every output is at its reset value and no grf write occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and the result-FIFO entry layout for the write-back arbiter.
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    // One pending mult/div result. The arbiter stores it as the flat
    // concatenation {rd, data, pc}, matching this packed layout.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for mult/div results. Push is ignored when full and pop
// is ignored when empty, so callers may present both freely in one cycle.
module wb_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full/empty are judged on the occupancy before this cycle's pop.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count alone decide validity, and this lets it map onto plain RAM.
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline W-stage writes with queued mult/div
// results onto the single GRF write port, and tracks registers still
// waiting on a mult/div result so decode can stall on them.
module wb_arbiter #(
    parameter int DEPTH  = wb_pkg::DEPTH,
    parameter int DATA_W = wb_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pipe_we,
    input  logic [wb_pkg::REG_W-1:0]      pipe_a3,
    input  logic [DATA_W-1:0]             pipe_wd,
    input  logic [DATA_W-1:0]             pipe_pc,
    input  logic                          md_issue,
    input  logic [wb_pkg::REG_W-1:0]      md_issue_reg,
    input  logic                          md_done,
    input  logic [wb_pkg::REG_W-1:0]      md_reg,
    input  logic [DATA_W-1:0]             md_data,
    input  logic [DATA_W-1:0]             md_pc,
    output logic                          md_ready,
    input  logic [wb_pkg::REG_W-1:0]      rs_q,
    input  logic [wb_pkg::REG_W-1:0]      rt_q,
    output logic                          stall,
    output logic                          grf_we,
    output logic [wb_pkg::REG_W-1:0]      grf_a3,
    output logic [DATA_W-1:0]             grf_wd,
    output logic [DATA_W-1:0]             grf_pc,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_cnt,
    output logic                          ovf
);

    localparam int REG_W   = wb_pkg::REG_W;
    localparam int ENTRY_W = REG_W + 2 * DATA_W;

    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head;
    logic [REG_W-1:0]     head_reg;
    logic [DATA_W-1:0]    head_data;
    logic [DATA_W-1:0]    head_pc;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pipe_win;
    logic                 pop_en;
    logic [31:0]          pending;
    logic [31:0]          pending_nxt;

    // Entries are packed {rd, data, pc}, the same order as wb_entry_t.
    assign push_entry = {md_reg, md_data, md_pc};
    assign head_reg   = head[ENTRY_W-1 -: REG_W];
    assign head_data  = head[2*DATA_W-1 -: DATA_W];
    assign head_pc    = head[DATA_W-1:0];

    // A pipeline write to $0 is a no-op, so it never blocks the FIFO.
    assign pipe_win = pipe_we && (pipe_a3 != '0);
    assign pop_en   = !pipe_win && !fifo_empty;
    assign md_ready = !fifo_full;
    assign stall    = pending[rs_q] | pending[rt_q];

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (md_done),
        .pop   (pop_en),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Scoreboard update: retire the popped register, then apply a new
    // reservation so that a same-cycle issue to that register wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        pending_nxt = pending;
        if (pop_en && (head_reg != '0)) pending_nxt[head_reg] = 1'b0;
        if (md_issue && (md_issue_reg != '0)) pending_nxt[md_issue_reg] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (md_done && fifo_full) ovf <= 1'b1;
        end
    end

    // Registered GRF write port; data fields hold when nothing is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
        end else if (pipe_win) begin
            grf_we <= 1'b1;
            grf_a3 <= pipe_a3;
            grf_wd <= pipe_wd;
            grf_pc <= pipe_pc;
        end else if (pop_en) begin
            grf_we <= (head_reg != '0);
            grf_a3 <= head_reg;
            grf_wd <= head_data;
            grf_pc <= head_pc;
        end else begin
            grf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = wb_pkg::DEPTH;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        md_done;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic [31:0] md_pc;
    logic        md_ready;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic        stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [1:0]  fifo_cnt;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    wb_pkg::wb_entry_t mq[$];
    logic [31:0]       m_pending;
    logic              m_ovf;
    logic              m_we;
    logic [4:0]        m_a3;
    logic [31:0]       m_wd;
    logic [31:0]       m_pc;

    wb_arbiter #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_we      (pipe_we),
        .pipe_a3      (pipe_a3),
        .pipe_wd      (pipe_wd),
        .pipe_pc      (pipe_pc),
        .md_issue     (md_issue),
        .md_issue_reg (md_issue_reg),
        .md_done      (md_done),
        .md_reg       (md_reg),
        .md_data      (md_data),
        .md_pc        (md_pc),
        .md_ready     (md_ready),
        .rs_q         (rs_q),
        .rt_q         (rt_q),
        .stall        (stall),
        .grf_we       (grf_we),
        .grf_a3       (grf_a3),
        .grf_wd       (grf_wd),
        .grf_pc       (grf_pc),
        .fifo_cnt     (fifo_cnt),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("md_ready", 64'(md_ready), 64'(mq.size() < DEPTH));
        check("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
        check("ovf",      64'(ovf),      64'(m_ovf));
        check("stall",    64'(stall),    64'(m_pending[rs_q] | m_pending[rt_q]));
        check("grf_we",   64'(grf_we),   64'(m_we));
        check("grf_a3",   64'(grf_a3),   64'(m_a3));
        check("grf_wd",   64'(grf_wd),   64'(m_wd));
        check("grf_pc",   64'(grf_pc),   64'(m_pc));
    endtask

    task automatic model_reset();
        mq.delete();
        m_pending = '0;
        m_ovf     = 1'b0;
        m_we      = 1'b0;
        m_a3      = '0;
        m_wd      = '0;
        m_pc      = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        wb_pkg::wb_entry_t e;
        bit was_full;
        if (reset) begin
            model_reset();
        end else begin
            was_full = (mq.size() == DEPTH);
            if (pipe_we && pipe_a3 != 0) begin
                m_we = 1'b1;
                m_a3 = pipe_a3;
                m_wd = pipe_wd;
                m_pc = pipe_pc;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = (e.rd != 0);
                m_a3 = e.rd;
                m_wd = e.data;
                m_pc = e.pc;
                m_pending[e.rd] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (md_issue && md_issue_reg != 0) m_pending[md_issue_reg] = 1'b1;
            if (md_done) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back('{rd: md_reg, data: md_data, pc: md_pc});
            end
            m_pending[0] = 1'b0;
        end
    endtask

    // Check outputs mid-cycle, step the model, then let the edge happen.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset        = 1'b0;
        pipe_we      = 1'b0;
        pipe_a3      = '0;
        pipe_wd      = '0;
        pipe_pc      = '0;
        md_issue     = 1'b0;
        md_issue_reg = '0;
        md_done      = 1'b0;
        md_reg       = '0;
        md_data      = '0;
        md_pc        = '0;
        rs_q         = '0;
        rt_q         = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        cycle();

        // Pipeline write with empty FIFO.
        idle();
        pipe_we = 1'b1; pipe_a3 = 5'd5; pipe_wd = 32'h1234; pipe_pc = 32'h100;
        cycle();
        idle();
        cycle();

        // Issue to $8, stall on it, then the result retires through the FIFO.
        idle(); md_issue = 1'b1; md_issue_reg = 5'd8;
        cycle();
        idle(); rs_q = 5'd8;
        cycle();
        md_done = 1'b1; md_reg = 5'd8; md_data = 32'hBEEF; md_pc = 32'h200;
        cycle();
        idle(); rs_q = 5'd8;
        cycle();
        cycle();
        cycle();

        // Pipeline holds priority while the FIFO fills and overflows.
        idle(); md_issue = 1'b1; md_issue_reg = 5'd10;
        cycle();
        md_issue_reg = 5'd11;
        cycle();
        for (int i = 0; i < 4; i++) begin
            idle();
            pipe_we = 1'b1; pipe_a3 = 5'd3; pipe_wd = 32'hA000 + i; pipe_pc = 32'h300 + 4 * i;
            if (i < 3) begin
                md_done = 1'b1; md_reg = 5'd10 + 5'(i); md_data = 32'hD000 + i; md_pc = 32'h400 + 4 * i;
            end
            rs_q = 5'd10; rt_q = 5'd11;
            cycle();
        end
        idle(); rs_q = 5'd10; rt_q = 5'd11;
        cycle();
        cycle();
        cycle();

        // Same-cycle issue and pop of $9: the reservation survives.
        idle(); md_issue = 1'b1; md_issue_reg = 5'd9;
        cycle();
        idle(); md_done = 1'b1; md_reg = 5'd9; md_data = 32'h9999; md_pc = 32'h500;
        cycle();
        idle(); md_issue = 1'b1; md_issue_reg = 5'd9; rs_q = 5'd9;
        cycle();
        idle(); rs_q = 5'd9;
        cycle();

        // Writes to $0: pipeline no-op and a reg-0 entry still consumed.
        idle(); md_done = 1'b1; md_reg = 5'd0; md_data = 32'h0BAD; md_pc = 32'h600;
        cycle();
        idle(); pipe_we = 1'b1; pipe_a3 = 5'd0; pipe_wd = 32'hFFFF; pipe_pc = 32'h604;
        cycle();
        idle();
        cycle();

        // Reset with a full FIFO and reservations outstanding.
        idle(); md_issue = 1'b1; md_issue_reg = 5'd20;
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            pipe_we = 1'b1; pipe_a3 = 5'd4; pipe_wd = 32'h44; pipe_pc = 32'h700;
            md_done = 1'b1; md_reg = 5'd20 + 5'(i); md_data = 32'hC0 + i; md_pc = 32'h800;
            cycle();
        end
        idle(); reset = 1'b1; pipe_we = 1'b1; pipe_a3 = 5'd6; md_done = 1'b1; md_reg = 5'd7;
        md_issue = 1'b1; md_issue_reg = 5'd12; rs_q = 5'd20;
        cycle();
        idle(); rs_q = 5'd20; rt_q = 5'd12;
        cycle();
        cycle();

        // Random traffic on a narrow register range to force collisions.
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            pipe_we      = ($urandom_range(0, 1) == 1);
            pipe_a3      = 5'($urandom_range(0, 7));
            pipe_wd      = $urandom;
            pipe_pc      = $urandom;
            md_issue     = ($urandom_range(0, 2) == 0);
            md_issue_reg = 5'($urandom_range(0, 7));
            md_done      = ($urandom_range(0, 4) < 2);
            md_reg       = 5'($urandom_range(0, 7));
            md_data      = $urandom;
            md_pc        = $urandom;
            rs_q         = 5'($urandom_range(0, 7));
            rt_q         = 5'($urandom_range(0, 7));
            cycle();
        end
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
